// File: rtl/rtc_pkg.sv
// Shared definitions for the Wishbone real-time clock: register map, bit fields,
// bus access-size encoding and the handshake state type.
package rtc_pkg;

  localparam logic [1:0] RTC_CTRL    = 2'd0;
  localparam logic [1:0] RTC_DIV     = 2'd1;
  localparam logic [1:0] RTC_SECONDS = 2'd2;
  localparam logic [1:0] RTC_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int STATUS_PEND_BIT = 0;

  // i_wb_sel[1:0] access size, common to the whole data bus
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rtc_prescaler.sv
// Prescaler: counts enabled clock cycles and strobes tick when the divider is reached.
// tick is combinational so the parent can update its registers on the same edge.
module rtc_prescaler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] div,
  input  logic            clear,
  output logic            tick
);

  logic [XLEN-1:0] count;
  logic [XLEN-1:0] limit;

  // A divider of 0 behaves like 1; >= keeps a shrunken divider from skipping a tick
  assign limit = (div == '0) ? '0 : div - XLEN'(1);
  assign tick  = en && (count >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + XLEN'(1);
    end
  end

endmodule

// File: rtl/wb_rtc.sv
// Wishbone-style pipelined responder holding the RTC registers and the
// IDLE/RESP handshake; the prescaler supplies the per-second strobe.
module wb_rtc
  import rtc_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int unsigned DEFAULT_DIV = 1000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_stb,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_wb_we,
  input  logic [2:0]      i_wb_sel,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic            o_tick
);

  wb_state_t       state_q, state_d;
  logic            accept;
  logic            ctrl_en;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] seconds_q;
  logic            pend_q;
  logic            tick_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rd_value;
  logic            fire;
  logic [1:0]      reg_sel;
  logic            aligned;
  logic            wr_ok;
  logic            wr_ctrl, wr_div, wr_seconds, wr_status;
  logic            unused_ok;

  assign reg_sel   = i_addr[3:2];
  assign aligned   = (i_addr[1:0] == 2'b00);
  assign unused_ok = ^{i_addr[XLEN-1:4], i_wb_sel[2]};

  assign wr_ok      = accept && i_wb_we && (i_wb_sel[1:0] == SIZE_WORD) && aligned;
  assign wr_ctrl    = wr_ok && (reg_sel == RTC_CTRL);
  assign wr_div     = wr_ok && (reg_sel == RTC_DIV);
  assign wr_seconds = wr_ok && (reg_sel == RTC_SECONDS);
  assign wr_status  = wr_ok && (reg_sel == RTC_STATUS);

  rtc_prescaler #(.XLEN(XLEN)) u_prescaler (
    .clk   (i_clk),
    .rst   (i_reset),
    .en    (ctrl_en),
    .div   (div_q),
    .clear (wr_seconds),
    .tick  (fire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    o_wb_ack   = 1'b0;
    o_wb_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wb_stb) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        o_wb_ack   = 1'b1;
        o_wb_stall = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is snapshotted at acceptance, so a tick during RESP is not visible
  always_comb begin
    rd_value = '0;
    if (aligned) begin
      case (reg_sel)
        RTC_CTRL:    rd_value[CTRL_EN_BIT]     = ctrl_en;
        RTC_DIV:     rd_value                  = div_q;
        RTC_SECONDS: rd_value                  = seconds_q;
        RTC_STATUS:  rd_value[STATUS_PEND_BIT] = pend_q;
        default:     rd_value                  = '0;
      endcase
    end
  end

  // A bus write beats the increment on SECONDS, but a tick beats the PEND clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_en   <= 1'b0;
      div_q     <= XLEN'(DEFAULT_DIV);
      seconds_q <= '0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      tick_q <= fire;
      if (wr_ctrl) begin
        ctrl_en <= i_data[CTRL_EN_BIT];
      end
      if (wr_div) begin
        div_q <= i_data;
      end
      if (wr_seconds) begin
        seconds_q <= i_data;
      end else if (fire) begin
        seconds_q <= seconds_q + XLEN'(1);
      end
      if (fire) begin
        pend_q <= 1'b1;
      end else if (wr_status && i_data[STATUS_PEND_BIT]) begin
        pend_q <= 1'b0;
      end
      if (accept) begin
        rdata_q <= rd_value;
      end
    end
  end

  assign o_wb_data = o_wb_ack ? rdata_q : '0;
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_wb_rtc.sv
// Directed self-checking bench for wb_rtc: register access, prescaler ticking,
// same-cycle event priorities, handshake throughput and asynchronous reset.
module tb_wb_rtc;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_wb_stb;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_wb_we;
  logic [2:0]  i_wb_sel;
  logic [31:0] o_wb_data;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic        o_tick;

  int total_checks = 0;
  int bad_checks   = 0;

  logic [31:0] rd;
  logic        acked;
  logic [4:0]  ack_pattern;
  int          ack_count;
  int          period;

  wb_rtc #(.XLEN(32), .DEFAULT_DIV(1000000)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wb_stb   (i_wb_stb),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_wb_we    (i_wb_we),
    .i_wb_sel   (i_wb_sel),
    .o_wb_data  (o_wb_data),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_tick     (o_tick)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus transaction; enters and leaves 1 time unit after a rising edge
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] sel, output logic [31:0] rdata, output logic ack);
    int guard = 0;
    while (o_wb_stall && guard < 8) begin
      @(posedge i_clk); #1;
      guard++;
    end
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_addr   = addr;
    i_data   = wdata;
    i_wb_sel = sel;
    @(posedge i_clk); #1;
    ack      = o_wb_ack;
    rdata    = o_wb_data;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    logic        a;
    applyStimulus(1'b1, addr, wdata, 3'b010, dummy, a);
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] rdata);
    logic a;
    applyStimulus(1'b0, addr, 32'h0, 3'b010, rdata, a);
  endtask

  task automatic waitTick(input string tag, input int limit);
    int n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!o_tick && n < limit);
    checkOutput(tag, o_tick, 1'b1);
  endtask

  task automatic tickPeriod(output int n);
    n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!o_tick && n < 12);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset  = 1'b1;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    i_addr   = '0;
    i_data   = '0;
    i_wb_sel = 3'b010;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_ack", o_wb_ack, 1'b0);
    checkOutput("reset_stall", o_wb_stall, 1'b0);
    checkOutput("reset_tick", o_tick, 1'b0);
    checkOutput("reset_data", o_wb_data, 32'h0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // SECONDS read with explicit handshake timing
    checkOutput("idle_stall", o_wb_stall, 1'b0);
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_addr   = 32'h8;
    i_wb_sel = 3'b010;
    @(posedge i_clk); #1;
    checkOutput("rd_ack", o_wb_ack, 1'b1);
    checkOutput("rd_stall", o_wb_stall, 1'b1);
    checkOutput("rd_seconds_reset", o_wb_data, 32'h0);
    i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("ack_drop", o_wb_ack, 1'b0);
    checkOutput("stall_drop", o_wb_stall, 1'b0);
    busRead(32'h4, rd);
    checkOutput("div_reset", rd, 32'd1000000);

    // DIV=4 ticking
    busWrite(32'h4, 32'd4);
    busWrite(32'h0, 32'd1);
    waitTick("tick1_seen", 12);
    tickPeriod(period);
    checkOutput("tick_period_a", period, 32'd4);
    tickPeriod(period);
    checkOutput("tick_period_b", period, 32'd4);
    busRead(32'h8, rd);
    checkOutput("seconds_after_3", rd, 32'd3);
    busRead(32'hC, rd);
    checkOutput("status_pend", rd, 32'd1);
    busWrite(32'h0, 32'd0);
    busWrite(32'hC, 32'd1);
    busRead(32'hC, rd);
    checkOutput("status_cleared", rd, 32'd0);

    // DIV=3: PEND clear lands on a tick edge
    busWrite(32'h4, 32'd3);
    busWrite(32'h0, 32'd1);
    waitTick("tick_div3_a", 12);
    repeat (2) begin @(posedge i_clk); #1; end
    busWrite(32'hC, 32'd1);
    busRead(32'hC, rd);
    checkOutput("pend_set_wins", rd, 32'd1);

    // DIV=3: SECONDS write lands on a tick edge
    waitTick("tick_div3_b", 12);
    repeat (2) begin @(posedge i_clk); #1; end
    busWrite(32'h8, 32'h10);
    busRead(32'h8, rd);
    checkOutput("seconds_write_wins", rd, 32'h10);

    // DIV=1 wrap
    busWrite(32'h4, 32'd1);
    busWrite(32'h8, 32'hFFFF_FFFF);
    checkOutput("wrap_tick", o_tick, 1'b1);
    busRead(32'h8, rd);
    checkOutput("wrap_seconds", rd, 32'h0);
    busWrite(32'h0, 32'd0);

    // Strobe held for 4 cycles
    ack_pattern = '0;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_addr   = 32'h0;
    i_wb_sel = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      ack_pattern[i] = o_wb_ack;
    end
    i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    ack_pattern[4] = o_wb_ack;
    ack_count = $countones(ack_pattern);
    checkOutput("b2b_ack_pattern", ack_pattern, 5'b00101);
    checkOutput("b2b_ack_count", ack_count, 32'd2);

    // Byte write dropped, misaligned read
    applyStimulus(1'b1, 32'h0, 32'd1, 3'b000, rd, acked);
    checkOutput("byte_write_ack", acked, 1'b1);
    busRead(32'h0, rd);
    checkOutput("ctrl_after_byte", rd, 32'd0);
    applyStimulus(1'b0, 32'h9, 32'h0, 3'b010, rd, acked);
    checkOutput("misaligned_ack", acked, 1'b1);
    checkOutput("misaligned_data", rd, 32'h0);

    // Reset during RESP
    busWrite(32'h4, 32'd7);
    busWrite(32'h8, 32'h55);
    busWrite(32'h0, 32'd1);
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_addr   = 32'h4;
    i_wb_sel = 3'b010;
    @(posedge i_clk); #1;
    checkOutput("pre_reset_ack", o_wb_ack, 1'b1);
    i_reset = 1'b1;
    #1;
    checkOutput("async_ack_drop", o_wb_ack, 1'b0);
    checkOutput("async_stall_drop", o_wb_stall, 1'b0);
    checkOutput("async_tick_drop", o_tick, 1'b0);
    i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    busRead(32'h4, rd);
    checkOutput("div_after_reset", rd, 32'd1000000);
    busRead(32'h8, rd);
    checkOutput("seconds_after_reset", rd, 32'h0);
    busRead(32'h0, rd);
    checkOutput("ctrl_after_reset", rd, 32'h0);
    busRead(32'hC, rd);
    checkOutput("status_after_reset", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/wb_rtc.md
# wb_rtc

Wishbone-style pipelined responder exposing a real-time seconds counter to the hart's data port. Sits beside `block_ram` on the data bus, selected by an external address decoder, and answers the same `stb`/`stall`/`ack` handshake the hart issues as initiator. Provides a programmable prescaler, a read/write seconds register, a sticky tick flag, and a one-cycle tick pulse for the clock display logic.

## Interface
- `XLEN`, 32, data/address width; only 32 is supported.
- `DEFAULT_DIV`, 1000000, prescaler divider loaded at reset (clock cycles per second).
- `i_clk  in  1  clock`
- `i_reset  in  1  reset: asynchronous, active-high`
- `i_wb_stb  in  1  request strobe; accepted when `o_wb_stall`=0`
- `i_addr  in  XLEN  byte address; only `[3:2]` decoded, `[1:0]` must be 0`
- `i_data  in  XLEN  write data`
- `i_wb_we  in  1  1 = write, 0 = read`
- `i_wb_sel  in  3  access size: `[1:0]` 00 byte, 01 half, 10 word; `[2]` unsigned flag (ignored)`
- `o_wb_data  out  XLEN  read data, valid while `o_wb_ack`=1`
- `o_wb_stall  out  1  responder busy`
- `o_wb_ack  out  1  one-cycle response pulse`
- `o_tick  out  1  one-cycle pulse on every seconds increment`

## Operation
- Registers, by `i_addr[3:2]`:
  - 0 CTRL: bit0 EN (counting enable); other bits read 0.
  - 1 DIV: divider, 32 bits.
  - 2 SECONDS: 32-bit counter.
  - 3 STATUS: bit0 PEND (sticky tick flag); write 1 to clear.
- Reset values: CTRL=0, DIV=`DEFAULT_DIV`, SECONDS=0, PEND=0, prescaler count=0. Outputs `o_wb_ack`=0, `o_wb_stall`=0, `o_wb_data`=0, `o_tick`=0.
- Prescaler: while EN=1, count increments each cycle. When count ≥ DIV−1, count←0, SECONDS←SECONDS+1 (wraps FFFFFFFF→0), PEND←1, `o_tick`=1. DIV=0 is treated as DIV=1, giving a tick every cycle. While EN=0, count holds.
- A DIV write takes effect on the next comparison. Count is not reset. Because the comparison is ≥, a smaller DIV never causes a missed tick.
- Writes apply only for word size (`i_wb_sel[1:0]`=10) with `i_addr[1:0]`=0. Any other write is dropped but still acked.
- Reads return the full register regardless of size. A misaligned read returns 0.
- Simultaneous events:
  - SECONDS write in a tick cycle: the written value wins, count←0, `o_tick` still pulses, PEND←1.
  - PEND clear in a tick cycle: the set wins, so PEND=1.
  - Writing CTRL.EN=0 in a tick cycle: that tick still completes.
- Reset mid-transaction: pending ack is discarded, and all state returns to reset values immediately (asynchronous).

## Timing
- Handshake FSM, states IDLE and RESP.
  - IDLE: `o_wb_stall`=0. On `i_wb_stb`=1, latch the request and perform the write at this edge, then go to RESP.
  - RESP: `o_wb_ack`=1, `o_wb_stall`=1, `o_wb_data` valid. Unconditionally return to IDLE.
- `i_wb_stb` during RESP is not accepted. The initiator holds it, and it is accepted in the following IDLE cycle.
- Latency: ack exactly 1 cycle after acceptance. Maximum throughput is one transaction per 2 cycles.
- Read data is sampled at acceptance. A tick landing in the RESP cycle is not reflected in that response.
- `o_tick` is registered: it is high in the same cycle the new SECONDS value is first visible, and never high two cycles in a row unless DIV≤1.

## Structure
- Package `rtc_pkg` holds:
  - register offset constants (`RTC_CTRL`, `RTC_DIV`, `RTC_SECONDS`, `RTC_STATUS`);
  - CTRL/STATUS bit positions;
  - the `i_wb_sel` size encoding (shared with `block_ram` and the hart);
  - the FSM state enum.
- Sub-module `rtc_prescaler`: count, DIV compare, EN, and tick generation. Its inputs are an enable, the divider, and a count-clear; its output is the tick. The top holds the registers and the handshake FSM.

## Test plan
- Reset, then read SECONDS at offset 8: ack 1 cycle after acceptance with data 0, `o_wb_stall` high only in the ack cycle, DIV reads 1000000.
- Write DIV=4, then CTRL=1: `o_tick` pulses every 4 cycles, SECONDS reads 3 after 3 pulses, STATUS reads 1; write STATUS=1 → STATUS reads 0.
- Write SECONDS=FFFFFFFF with DIV=1, EN=1: next cycle SECONDS=0 and `o_tick`=1.
- STATUS clear and tick in the same cycle: STATUS reads 1 afterwards. SECONDS write of 0x10 coincident with a tick: SECONDS reads 0x10.
- Back-to-back `i_wb_stb` held high for 4 cycles: exactly 2 acks, on cycles 1 and 3. A byte write (sel=000) to CTRL is acked and CTRL stays 0. A read at address 0x9 returns 0.
- Assert `i_reset` during RESP: `o_wb_ack` drops immediately, and all registers return to their reset values.
